// File: rtl/axis_fft_8point_dft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : axis_fft8_pkg
//  Brief    : Shared constants, complex-word types and the Q15 twiddle helper
//             for the 8-point forward FFT.
//  Config   : AXIS_FFT8_SKID_EN selects the pipeline latency constant.
//  Revision : 1.0 - initial release
// ============================================================================
package axis_fft8_pkg;

  localparam int C_ACC_WIDTH     = 32;
  localparam int C_TWIDDLE       = 23170;  // 0.7071 in Q15
  localparam int C_TWIDDLE_SHIFT = 15;

`ifdef AXIS_FFT8_SKID_EN
  localparam int C_PIPE_LATENCY  = 5;
`else
  localparam int C_PIPE_LATENCY  = 4;
`endif

  // One complex bin; re sits in the upper half so a packed array of these
  // matches the {Xk_re, Xk_im} output word layout directly.
  typedef struct packed {
    logic signed [C_ACC_WIDTH-1:0] re;
    logic signed [C_ACC_WIDTH-1:0] im;
  } cplx_t;

  typedef cplx_t [7:0] cplx_vec_t;

  // Q15 multiply with floor (arithmetic shift, no rounding).
  function automatic logic signed [C_ACC_WIDTH-1:0] twiddle_mul(
    input logic signed [C_ACC_WIDTH-1:0] a,
    input int                            c
  );
    logic signed [C_ACC_WIDTH-1:0] prod;
    prod = a * C_ACC_WIDTH'(c);
    return prod >>> C_TWIDDLE_SHIFT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axis_fft_8point_dft_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_fft_8point_dft_if
//  Brief    : AXI4-Stream bundle (tvalid/tready/tdata/tlast) with master and
//             slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface axis_fft_8point_dft_if #(
  parameter int DATA_W = 64
) ();

  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input  tready);
  modport slave  (input  tvalid, input  tdata, input  tlast, output tready);

endinterface
`default_nettype wire

// File: rtl/axis_fft_8point_dft_skid.sv
`default_nettype none
// ============================================================================
//  Module   : axis_fft8_skid
//  Brief    : Generic 2-entry AXI-Stream skid buffer. Upstream ready is a
//             register (not-full), so downstream ready never reaches it
//             combinationally.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_fft8_skid #(
  parameter int WIDTH = 513
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             s_valid_i,
  output logic                  s_ready_o,
  input  wire logic [WIDTH-1:0] s_data_i,
  output logic                  m_valid_o,
  input  wire logic             m_ready_i,
  output logic [WIDTH-1:0]      m_data_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic             full_q;
  logic             push;
  logic             pop;

  assign s_ready_o = ~full_q;
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = mem_q[rd_ptr_q];
  assign push      = s_valid_i & ~full_q;
  assign pop       = m_valid_o & m_ready_i;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    cnt_d = cnt_q + 2'(push) - 2'(pop);
  end

  // Storage, pointers and the registered full flag; empty after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
      full_q   <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= s_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == 2'd2);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axis_fft_8point_dft.sv
`default_nettype none
// ============================================================================
//  Module   : axis_fft_8point_dft
//  Brief    : Forward 8-point radix-2 DIF FFT on AXI4-Stream. One beat of
//             8 x int8 real samples in, one beat of 8 x {re32,im32} out.
//             Four-stage fixed-latency pipeline with a global stall enable.
//  Config   : AXIS_FFT8_SKID_EN adds a 2-entry output skid buffer
//             (latency 5, registered s_axis_tready).
//  Revision : 1.0 - initial release
// ============================================================================
module axis_fft_8point_dft
  import axis_fft8_pkg::*;
#(
  parameter int C_AXIS_TDATA_WIDTH = 64,
  parameter int C_AXIS_TOUT_WIDTH  = 512,
  parameter int C_SAMPLE_WIDTH     = 8,
  parameter int C_ACC_WIDTH        = 32
) (
  input  wire logic             s_axis_aclk,
  input  wire logic             s_axis_aresetn,
  axis_fft_8point_dft_if.slave  s_axis,
  axis_fft_8point_dft_if.master m_axis
);

  localparam int C_NPTS = C_AXIS_TDATA_WIDTH / C_SAMPLE_WIDTH;

  typedef logic signed [C_ACC_WIDTH-1:0] acc_t;

  logic       en;
  logic [3:0] vld_q;
  logic [3:0] last_q;

  acc_t x_d [8];
  acc_t x_q [8];
  acc_t e_d [4];
  acc_t e_q [4];
  acc_t o_d [4];
  acc_t o_q [4];
  acc_t ee_d [2];
  acc_t ee_q [2];
  acc_t eo_d [2];
  acc_t eo_q [2];
  acc_t o0_d, o0_q, o2_d, o2_q, p_d, p_q, q_d, q_q;
  cplx_vec_t out_d;
  cplx_vec_t out_q;

  // Stage 0 next value: sign-extend each int8 sample.
  always_comb begin
    for (int k = 0; k < 8; k++) x_d[k] = '0;
    for (int k = 0; k < C_NPTS; k++) begin
      x_d[k] = acc_t'(signed'(s_axis.tdata[C_SAMPLE_WIDTH*k +: C_SAMPLE_WIDTH]));
    end
  end

  // Stage 1 next value: first DIF butterfly layer.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      e_d[k] = x_q[k] + x_q[k+4];
      o_d[k] = x_q[k] - x_q[k+4];
    end
  end

  // Stage 2 next value: even half butterflies, odd half twiddles by +-0.7071.
  always_comb begin
    ee_d[0] = e_q[0] + e_q[2];
    ee_d[1] = e_q[1] + e_q[3];
    eo_d[0] = e_q[0] - e_q[2];
    eo_d[1] = e_q[1] - e_q[3];
    o0_d    = o_q[0];
    o2_d    = o_q[2];
    p_d     = twiddle_mul(o_q[1] - o_q[3], C_TWIDDLE);
    q_d     = twiddle_mul(o_q[1] + o_q[3], -C_TWIDDLE);
  end

  // Stage 3 next value: final butterflies into the packed bin layout.
  always_comb begin
    out_d       = '0;
    out_d[0].re = ee_q[0] + ee_q[1];
    out_d[4].re = ee_q[0] - ee_q[1];
    out_d[2].re = eo_q[0];
    out_d[2].im = -eo_q[1];
    out_d[6].re = eo_q[0];
    out_d[6].im = eo_q[1];
    out_d[1].re = o0_q + p_q;
    out_d[1].im = q_q - o2_q;
    out_d[5].re = o0_q - p_q;
    out_d[5].im = -(o2_q + q_q);
    out_d[3].re = o0_q - p_q;
    out_d[3].im = o2_q + q_q;
    out_d[7].re = o0_q + p_q;
    out_d[7].im = o2_q - q_q;
  end

  // Valid and tlast travel with their data; bubbles are kept, not collapsed.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      vld_q  <= '0;
      last_q <= '0;
    end else if (en) begin
      vld_q  <= {vld_q[2:0], s_axis.tvalid};
      last_q <= {last_q[2:0], s_axis.tvalid & s_axis.tlast};
    end
  end

  // Data registers for stages 0 and 1.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      for (int k = 0; k < 8; k++) x_q[k] <= '0;
      for (int k = 0; k < 4; k++) begin
        e_q[k] <= '0;
        o_q[k] <= '0;
      end
    end else if (en) begin
      for (int k = 0; k < 8; k++) x_q[k] <= x_d[k];
      for (int k = 0; k < 4; k++) begin
        e_q[k] <= e_d[k];
        o_q[k] <= o_d[k];
      end
    end
  end

  // Data registers for stages 2 and 3.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      ee_q[0] <= '0;
      ee_q[1] <= '0;
      eo_q[0] <= '0;
      eo_q[1] <= '0;
      o0_q    <= '0;
      o2_q    <= '0;
      p_q     <= '0;
      q_q     <= '0;
      out_q   <= '0;
    end else if (en) begin
      ee_q[0] <= ee_d[0];
      ee_q[1] <= ee_d[1];
      eo_q[0] <= eo_d[0];
      eo_q[1] <= eo_d[1];
      o0_q    <= o0_d;
      o2_q    <= o2_d;
      p_q     <= p_d;
      q_q     <= q_d;
      out_q   <= out_d;
    end
  end

`ifdef AXIS_FFT8_SKID_EN
  // The skid buffer decouples the pipeline from downstream ready; the
  // pipeline advances whenever the buffer has a free slot.
  logic skid_ready;

  assign en            = skid_ready;
  assign s_axis.tready = skid_ready;

  axis_fft8_skid #(
    .WIDTH (C_AXIS_TOUT_WIDTH + 1)
  ) u_skid (
    .clk       (s_axis_aclk),
    .rst_n     (s_axis_aresetn),
    .s_valid_i (vld_q[3]),
    .s_ready_o (skid_ready),
    .s_data_i  ({last_q[3], C_AXIS_TOUT_WIDTH'(out_q)}),
    .m_valid_o (m_axis.tvalid),
    .m_ready_i (m_axis.tready),
    .m_data_o  ({m_axis.tlast, m_axis.tdata})
  );
`else
  // Stall everything while the output beat is held by the sink.
  assign en            = ~vld_q[3] | m_axis.tready;
  assign s_axis.tready = en;
  assign m_axis.tvalid = vld_q[3];
  assign m_axis.tlast  = last_q[3];
  assign m_axis.tdata  = C_AXIS_TOUT_WIDTH'(out_q);
`endif

endmodule
`default_nettype wire
